// File: rtl/logic_accum_fold.sv
// logic_accum_fold
//   Multi-lane framed accumulator. Each lane combines PAR_FRAME_LEN input beats
//   (add modulo 2^W or XOR, chosen per beat), folds the frame result with a
//   half-swapped copy of itself and presents it through a one-entry output
//   register with valid/ready backpressure.
//
// Ports
//   ib_clk         clock, rising edge
//   ib_rst_n       asynchronous active-low reset
//   ib_clear       synchronous abort of the partial frame
//   ib_mode        per-beat operation: 0 add, 1 XOR
//   ivG_data       input beat, lane l at [l*W +: W]
//   ib_valid       input beat valid
//   ob_ready       block accepts an input beat
//   ovG_data       folded frame result, lane-packed like ivG_data
//   ob_valid       output register occupied
//   ib_ready       downstream accepts the output
//   ovG_frame_cnt  delivered frame count, wraps
module logic_accum_fold #(
   parameter int PAR_DATA_BITS = 8,
   parameter int PAR_LANES     = 2,
   parameter int PAR_FRAME_LEN = 4
) (
   input  logic                               ib_clk,
   input  logic                               ib_rst_n,
   input  logic                               ib_clear,
   input  logic                               ib_mode,
   input  logic [PAR_LANES*PAR_DATA_BITS-1:0] ivG_data,
   input  logic                               ib_valid,
   output logic                               ob_ready,
   output logic [PAR_LANES*PAR_DATA_BITS-1:0] ovG_data,
   output logic                               ob_valid,
   input  logic                               ib_ready,
   output logic [15:0]                        ovG_frame_cnt
);

   localparam int W     = PAR_DATA_BITS;
   localparam int L     = PAR_LANES;
   localparam int CNT_W = $clog2(PAR_FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAR_FRAME_LEN - 1);

   function automatic logic [W-1:0] beat_op(input logic [W-1:0] a,
                                            input logic [W-1:0] d,
                                            input logic         mode);
      beat_op = mode ? (a ^ d) : (a + d);
   endfunction

   function automatic logic [W-1:0] fold(input logic [W-1:0] s);
      fold = s ^ {s[W/2-1:0], s[W-1:W/2]};
   endfunction

   logic [L-1:0][W-1:0] acc;
   logic [L-1:0][W-1:0] acc_nxt;
   logic [L*W-1:0]      res_nxt;
   logic [CNT_W-1:0]    cnt;
   logic                at_last;
   logic                accept;
   logic                last_accept;
   logic                deliver;

   assign at_last     = (cnt == CNT_LAST);
   // Only the last beat of a frame needs the output slot, so only it stalls.
   assign ob_ready    = !ib_clear && !(at_last && ob_valid);
   assign accept      = ib_valid && ob_ready;
   assign last_accept = accept && at_last;
   assign deliver     = ob_valid && ib_ready;

   always_comb begin
      acc_nxt = '0;
      res_nxt = '0;
      for (int l = 0; l < L; l++) begin
         acc_nxt[l]         = beat_op(acc[l], ivG_data[l*W +: W], ib_mode);
         res_nxt[l*W +: W]  = fold(acc_nxt[l]);
      end
   end

   // Accumulation stage
   always_ff @(posedge ib_clk or negedge ib_rst_n) begin
      if (!ib_rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (ib_clear) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         if (at_last) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Output register stage
   always_ff @(posedge ib_clk or negedge ib_rst_n) begin
      if (!ib_rst_n) begin
         ovG_data      <= '0;
         ob_valid      <= 1'b0;
         ovG_frame_cnt <= '0;
      end else begin
         // A new frame load takes priority over clearing a delivered one.
         if (last_accept) begin
            ovG_data <= res_nxt;
            ob_valid <= 1'b1;
         end else if (deliver) begin
            ob_valid <= 1'b0;
         end
         if (deliver) begin
            ovG_frame_cnt <= ovG_frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_logic_accum_fold.sv
module tb_logic_accum_fold;

   localparam int W = 8;
   localparam int L = 2;
   localparam int N = 4;

   logic          ib_clk = 1'b0;
   logic          ib_rst_n = 1'b0;
   logic          ib_clear = 1'b0;
   logic          ib_mode = 1'b0;
   logic [L*W-1:0] ivG_data = '0;
   logic          ib_valid = 1'b0;
   logic          ob_ready;
   logic [L*W-1:0] ovG_data;
   logic          ob_valid;
   logic          ib_ready = 1'b1;
   logic [15:0]   ovG_frame_cnt;

   int checks = 0;
   int errors = 0;
   int stalls = 0;
   int delivered = 0;
   logic [L*W-1:0] exp_q[$];

   logic_accum_fold #(.PAR_DATA_BITS(W), .PAR_LANES(L), .PAR_FRAME_LEN(N)) dut (
      .ib_clk(ib_clk), .ib_rst_n(ib_rst_n), .ib_clear(ib_clear), .ib_mode(ib_mode),
      .ivG_data(ivG_data), .ib_valid(ib_valid), .ob_ready(ob_ready),
      .ovG_data(ovG_data), .ob_valid(ob_valid), .ib_ready(ib_ready),
      .ovG_frame_cnt(ovG_frame_cnt));

   always #5 ib_clk = ~ib_clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Scoreboard: every delivered frame is compared against the oldest expectation.
   always @(negedge ib_clk) begin
      if (ib_rst_n && ob_valid && ib_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame got=%h", ovG_data);
         end else begin
            logic [L*W-1:0] e;
            e = exp_q.pop_front();
            if (ovG_data !== e) begin
               errors++;
               $display("FAIL frame_data got=%h exp=%h", ovG_data, e);
            end
         end
         delivered++;
      end
   end

   function automatic logic [L*W-1:0] model(input logic [N-1:0][W-1:0] d0,
                                            input logic [N-1:0][W-1:0] d1,
                                            input logic [N-1:0] m);
      logic [W-1:0] s0, s1;
      s0 = '0;
      s1 = '0;
      for (int b = 0; b < N; b++) begin
         s0 = m[b] ? (s0 ^ d0[b]) : (s0 + d0[b]);
         s1 = m[b] ? (s1 ^ d1[b]) : (s1 + d1[b]);
      end
      model = {s1 ^ {s1[3:0], s1[7:4]}, s0 ^ {s0[3:0], s0[7:4]}};
   endfunction

   // Tasks start and end at posedge+1.
   task automatic send_beat(input logic [L*W-1:0] d, input logic md);
      int waited;
      waited = 0;
      ivG_data = d;
      ib_mode  = md;
      ib_valid = 1'b1;
      @(negedge ib_clk);
      while (!ob_ready && waited < 50) begin
         @(posedge ib_clk); #1;
         @(negedge ib_clk);
         waited++;
      end
      stalls += waited;
      if (!ob_ready) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout got=ob_ready0 exp=ob_ready1");
      end
      @(posedge ib_clk); #1;
   endtask

   task automatic send_frame(input logic [N-1:0][W-1:0] d0,
                             input logic [N-1:0][W-1:0] d1,
                             input logic [N-1:0] m);
      exp_q.push_back(model(d0, d1, m));
      for (int b = 0; b < N; b++) send_beat({d1[b], d0[b]}, m[b]);
   endtask

   task automatic idle(input int n);
      ib_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge ib_clk); #1;
      end
   endtask

   task automatic test_reset;
      ib_rst_n = 1'b0;
      #12;
      checks++; if (ob_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", ob_valid); end
      checks++; if (ovG_data !== '0) begin errors++; $display("FAIL rst_data got=%h exp=0", ovG_data); end
      checks++; if (ovG_frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", ovG_frame_cnt); end
      @(posedge ib_clk); #1;
      ib_rst_n = 1'b1;
      @(posedge ib_clk); #1;
      checks++; if (ob_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", ob_ready); end
   endtask

   task automatic test_add;
      send_frame({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'h80}}, 4'b0000);
      ib_valid = 1'b0;
      checks++; if (ob_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", ob_valid); end
      checks++; if (ovG_data !== 16'h00AA) begin errors++; $display("FAIL add_data got=%h exp=00aa", ovG_data); end
      @(posedge ib_clk); #1;
      checks++; if (ob_valid !== 1'b0) begin errors++; $display("FAIL add_valid_pulse got=%b exp=0", ob_valid); end
      checks++; if (ovG_frame_cnt !== 16'd1) begin errors++; $display("FAIL add_frame_cnt got=%0d exp=1", ovG_frame_cnt); end
      checks++; if (ovG_data !== 16'h00AA) begin errors++; $display("FAIL add_hold got=%h exp=00aa", ovG_data); end
   endtask

   task automatic test_xor;
      send_frame({8'd4, 8'd3, 8'd2, 8'd1}, {8'h00, 8'h00, 8'h00, 8'h0F}, 4'b1111);
      ib_valid = 1'b0;
      checks++; if (ovG_data !== 16'hFF44) begin errors++; $display("FAIL xor_data got=%h exp=ff44", ovG_data); end
      idle(1);
   endtask

   task automatic test_wrap;
      send_frame({8'h00, 8'h00, 8'h01, 8'hFF}, {4{8'h00}}, 4'b0000);
      ib_valid = 1'b0;
      checks++; if (ovG_data !== 16'h0000) begin errors++; $display("FAIL wrap_data got=%h exp=0000", ovG_data); end
      idle(1);
   endtask

   task automatic test_mixed;
      for (int f = 0; f < 4; f++) begin
         logic [N-1:0][W-1:0] d0, d1;
         logic [N-1:0] m;
         d0 = 32'($urandom);
         d1 = 32'($urandom);
         m  = 4'($urandom);
         send_frame(d0, d1, m);
         idle(1);
      end
   endtask

   task automatic test_back_to_back;
      int s0;
      s0 = stalls;
      for (int f = 0; f < 3; f++) begin
         logic [N-1:0][W-1:0] d0, d1;
         d0 = 32'($urandom);
         d1 = 32'($urandom);
         send_frame(d0, d1, {3'($urandom), 1'b0});
      end
      idle(2);
      checks++; if (stalls !== s0) begin errors++; $display("FAIL b2b_stalls got=%0d exp=%0d", stalls - s0, 0); end
   endtask

   task automatic test_backpressure;
      logic [N-1:0][W-1:0] a0, a1, b0, b1;
      logic [L*W-1:0] e1, e2;
      a0 = 32'($urandom); a1 = 32'($urandom);
      b0 = 32'($urandom); b1 = 32'($urandom);
      e1 = model(a0, a1, 4'b0000);
      e2 = model(b0, b1, 4'b0101);
      ib_ready = 1'b0;
      send_frame(a0, a1, 4'b0000);
      exp_q.push_back(e2);
      for (int b = 0; b < N - 1; b++) begin
         ivG_data = {b1[b], b0[b]};
         ib_mode  = b[0] ? 1'b0 : 1'b1;
         ib_valid = 1'b1;
         @(negedge ib_clk);
         checks++; if (ob_ready !== 1'b1) begin errors++; $display("FAIL bp_accept%0d got=%b exp=1", b, ob_ready); end
         @(posedge ib_clk); #1;
      end
      ivG_data = {b1[3], b0[3]};
      ib_mode  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge ib_clk);
         checks++; if (ob_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got=%b exp=0", ob_ready); end
         checks++; if (ovG_data !== e1) begin errors++; $display("FAIL bp_hold got=%h exp=%h", ovG_data, e1); end
         @(posedge ib_clk); #1;
      end
      ib_ready = 1'b1;
      @(negedge ib_clk);
      checks++; if (ob_ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready got=%b exp=0", ob_ready); end
      @(posedge ib_clk); #1;
      @(negedge ib_clk);
      checks++; if (ob_ready !== 1'b1) begin errors++; $display("FAIL bp_last_ready got=%b exp=1", ob_ready); end
      @(posedge ib_clk); #1;
      ib_valid = 1'b0;
      checks++; if (ob_valid !== 1'b1) begin errors++; $display("FAIL bp_f2_valid got=%b exp=1", ob_valid); end
      checks++; if (ovG_data !== e2) begin errors++; $display("FAIL bp_f2_data got=%h exp=%h", ovG_data, e2); end
      idle(2);
   endtask

   task automatic test_clear;
      ib_ready = 1'b1;
      send_beat(16'h3355, 1'b0);
      send_beat(16'h7711, 1'b1);
      ib_clear = 1'b1;
      ivG_data = 16'h9999;
      ib_valid = 1'b1;
      @(negedge ib_clk);
      checks++; if (ob_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got=%b exp=0", ob_ready); end
      @(posedge ib_clk); #1;
      ib_clear = 1'b0;
      send_frame({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'h00}}, 4'b0000);
      ib_valid = 1'b0;
      checks++; if (ovG_data !== 16'h00AA) begin errors++; $display("FAIL clear_data got=%h exp=00aa", ovG_data); end
      idle(2);
   endtask

   task automatic test_async_reset;
      logic [N-1:0][W-1:0] d0, d1;
      ib_ready = 1'b0;
      d0 = 32'($urandom); d1 = 32'($urandom);
      send_frame(d0, d1, 4'b1010);
      send_beat(16'h1234, 1'b0);
      send_beat(16'h5678, 1'b0);
      ib_valid = 1'b0;
      @(negedge ib_clk); #2;
      ib_rst_n = 1'b0;
      #1;
      checks++; if (ob_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", ob_valid); end
      checks++; if (ovG_data !== '0) begin errors++; $display("FAIL arst_data got=%h exp=0", ovG_data); end
      checks++; if (ovG_frame_cnt !== 16'd0) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", ovG_frame_cnt); end
      exp_q.delete();
      delivered = 0;
      @(posedge ib_clk); #1;
      ib_rst_n = 1'b1;
      ib_ready = 1'b1;
      send_frame({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'h80}}, 4'b0000);
      ib_valid = 1'b0;
      checks++; if (ovG_data !== 16'h00AA) begin errors++; $display("FAIL arst_frame got=%h exp=00aa", ovG_data); end
      idle(1);
      checks++; if (ovG_frame_cnt !== 16'd1) begin errors++; $display("FAIL arst_frame_cnt got=%0d exp=1", ovG_frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_xor();
      test_wrap();
      test_mixed();
      test_back_to_back();
      test_backpressure();
      test_clear();
      test_async_reset();
      idle(3);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL undelivered got=%0d exp=0", exp_q.size()); end
      checks++; if (ovG_frame_cnt !== 16'(delivered)) begin errors++; $display("FAIL final_frame_cnt got=%0d exp=%0d", ovG_frame_cnt, delivered); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/logic_accum_fold.md
# logic_accum_fold

Multi-lane framed accumulator with half-swap XOR folding and valid/ready flow control on both sides. Each of `PAR_LANES` lanes accumulates `PAR_FRAME_LEN` input beats (add or XOR per beat), folds the result and presents it through a one-entry output register with backpressure. It is the next-generation, parametrised, streaming version of the single-lane free-running sum/XOR logic stage in the multi-level hierarchy, and slots in at the same level.

## Interface
- `PAR_DATA_BITS`, 8: lane width W; must be even and at least 2.
- `PAR_LANES`, 2: number of independent lanes L, at least 1.
- `PAR_FRAME_LEN`, 4: beats per frame N, at least 2.
- `ib_clk` input 1: clock; all logic is on the rising edge.
- `ib_rst_n` input 1: reset, asynchronous, active-low.
- `ib_clear` input 1: synchronous frame abort.
- `ib_mode` input 1: per-beat operation; 0 adds, 1 XORs.
- `ivG_data` input L*W: lane l is bits [l*W+W-1 : l*W].
- `ib_valid` input 1: input beat valid.
- `ob_ready` output 1: the block accepts an input beat.
- `ovG_data` output L*W: folded frame result, lane-packed the same way as the input.
- `ob_valid` output 1: the output register is occupied.
- `ib_ready` input 1: downstream accepts the output.
- `ovG_frame_cnt` output 16: count of delivered frames; wraps.

## Operation
- Per lane, keep an accumulator `acc[l]` (W bits). Keep a beat counter `cnt` in the range 0..N-1.
- Input handshake: a beat is accepted when `ib_valid && ob_ready`.
- `ob_ready = !ib_clear && !(cnt==N-1 && ob_valid)`. It is registered-state based and has no combinational path from `ib_ready` or `ib_valid`.
- Accepted beat, `cnt < N-1`:
  - `acc[l] <= ib_mode ? acc[l]^d[l] : acc[l]+d[l]`, where the add is modulo 2^W and the carry is discarded.
  - `cnt` increments.
- Accepted beat, `cnt == N-1` (last beat):
  - Compute `s[l] = acc[l] op d[l]`.
  - Load `ovG_data` lane l with `s[l] ^ {s[l][W/2-1:0], s[l][W-1:W/2]}`.
  - Set `ob_valid`.
  - Clear all `acc` to 0 and set `cnt` to 0.
- Output handshake: a frame is delivered when `ob_valid && ib_ready`.
  - `ob_valid` clears and `ovG_frame_cnt` increments.
  - On the same cycle as a last-beat acceptance, the new frame's load wins: `ob_valid` stays 1 and `ovG_data` takes the new value. This cannot occur with the rule above, but implement load-over-clear priority anyway.
- Accumulation of the next frame proceeds while an output is pending. Only that frame's last beat stalls until the output slot frees.
- `ib_clear`:
  - Clears `acc` and `cnt` next edge; any partial frame is discarded.
  - No beat is accepted on that cycle.
  - `ovG_data`, `ob_valid` and `ovG_frame_cnt` are unaffected; a pending output still delivers normally.
- `ovG_data` holds its value while `ob_valid` is 0 and is stable while `ob_valid && !ib_ready`.

## Timing
- Reset (`ib_rst_n` low, asynchronous assert) clears:
  - `acc`, `cnt`, `ovG_data` to 0
  - `ob_valid` to 0
  - `ovG_frame_cnt` to 0
  - `ob_ready` reads 1 once reset is released, provided `ib_clear` is 0.
- Reset release is synchronised externally; the block requires no recovery cycles.
- Latency: `ob_valid` rises on the edge that accepts the last beat, so the result is visible the cycle after that beat.
- Throughput: one beat per cycle. With `ib_ready` tied high, there are no bubbles and one frame every N cycles.
- Reset mid-frame or mid-output: all state is lost immediately and the pending output is dropped.
- A mode change between beats applies per beat, so mixed add/XOR frames are legal and deterministic.
- Inputs are sampled only on accepted beats; `ivG_data` is don't-care otherwise.

## Test plan
Unless noted, W=8, L=2, N=4, `ib_ready`=1.
- Add mode: lane0 gets 1,2,3,4 and lane1 gets 0x80 ×4. Required: `ovG_data`=0x00AA (lane1 sum 0x00 wraps, lane0 sum 0x0A folds to 0xAA), `ob_valid` for 1 cycle, and `ovG_frame_cnt` becomes 1.
- XOR mode: lane0 gets 1,2,3,4 and lane1 gets 0x0F,0,0,0. Required: lane0=0x44, lane1=0xFF.
- Wrap: lane0 gets 0xFF,0x01,0x00,0x00 in add mode. Required: lane0=0x00.
- Backpressure: `ib_ready`=0 after frame 1, with continuous valid beats for frame 2. Required:
  - Three frame-2 beats are accepted, then `ob_ready`=0 at `cnt`=3.
  - `ovG_data` is held.
  - Raising `ib_ready` delivers frame 1, and the next cycle accepts frame 2's last beat.
- Clear: 2 beats, then `ib_clear` for 1 cycle with `ib_valid`=1, then 1,2,3,4 on lane0. Required:
  - `ob_ready`=0 during the clear.
  - Result 0xAA, unaffected by the pre-clear beats.
- Async reset: assert `ib_rst_n`=0 mid-frame while `ob_valid`=1. Required:
  - All outputs are 0 immediately, with no clock edge needed.
  - The next full frame produces the correct result and `ovG_frame_cnt`=1.
